// File: rtl/sub_dma_pkg.sv
// Shared definitions for the ASCON subsystem DMA bridges (sub_to_dma, dma_to_sub).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: return-path FSM state encoding and status-entry field layout.
package sub_dma_pkg;

    // Return-path frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_PAD  = 3'd3,
        S_AUTH = 3'd4,
        S_STAT = 3'd5
    } state_t;

    // Status entry layout: tag in the top MARKER_W bits, length just above the
    // data word, mode and auth result in the two lowest bits.
    localparam logic [15:0] MARKER       = 16'h5A5A;
    localparam int          MARKER_W     = 16;
    localparam int          STAT_DEC_BIT = 1;
    localparam int          STAT_OK_BIT  = 0;

endpackage

// File: rtl/sub_to_dma.sv
// Packs ASCON BDO words into 2*DW FIFO entries and closes each frame with a status entry.
// Latency: a pair is written the cycle after its upper-word transfer; status follows back-to-back.
// Backpressure: bdo_fifo_full_i stalls HI/PAD/STAT with data held; sub_bdo_rdy_o drops in HI.
//
// Ports: sub_clk_i/sub_rstn_i (sync active-low); frame_trigger_i + aead_dec_i open a frame;
// sub_bdo_* and sub_auth_* are vld/rdy inputs from the core; bdo_fifo_* is the FIFO write
// port; frame_done_o pulses with the status write; auth_fail_o is sticky until the next frame.
module sub_to_dma
    import sub_dma_pkg::*;
#(
    parameter int DW    = 32,
    parameter int LEN_W = 16
) (
    input  logic            sub_clk_i,
    input  logic            sub_rstn_i,
    input  logic            frame_trigger_i,
    input  logic            aead_dec_i,
    input  logic [DW-1:0]   sub_bdo_i,
    input  logic            sub_bdo_vld_i,
    input  logic            sub_bdo_last_i,
    output logic            sub_bdo_rdy_o,
    input  logic            sub_auth_vld_i,
    input  logic            sub_auth_i,
    output logic            sub_auth_rdy_o,
    input  logic            bdo_fifo_full_i,
    output logic            bdo_fifo_wr_o,
    output logic [2*DW-1:0] bdo_fifo_data_o,
    output logic            frame_done_o,
    output logic            auth_fail_o
);

    state_t             state_q;
    logic [DW-1:0]      lo_q;
    logic [LEN_W-1:0]   len_q;
    logic               dec_q;
    logic               ok_q;

    logic               bdo_xfer;
    logic [LEN_W-1:0]   len_inc;
    logic [2*DW-1:0]    status_dat;

    // LO only fills the holding register, so it never needs FIFO space.
    assign sub_bdo_rdy_o  = (state_q == S_LO) || ((state_q == S_HI) && !bdo_fifo_full_i);
    assign sub_auth_rdy_o = (state_q == S_AUTH);
    assign bdo_xfer       = sub_bdo_vld_i && sub_bdo_rdy_o;

    // Saturating word count: a runaway frame reports all-ones rather than wrapping.
    assign len_inc = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);

    always_comb begin
        status_dat                          = '0;
        status_dat[2*DW-1 -: MARKER_W]      = MARKER;
        status_dat[DW +: LEN_W]             = len_q;
        status_dat[STAT_DEC_BIT]            = dec_q;
        status_dat[STAT_OK_BIT]             = ok_q;
    end

    always_ff @(posedge sub_clk_i) begin
        if (!sub_rstn_i) begin
            state_q         <= S_IDLE;
            lo_q            <= '0;
            len_q           <= '0;
            dec_q           <= 1'b0;
            ok_q            <= 1'b0;
            bdo_fifo_wr_o   <= 1'b0;
            bdo_fifo_data_o <= '0;
            frame_done_o    <= 1'b0;
            auth_fail_o     <= 1'b0;
        end else begin
            bdo_fifo_wr_o <= 1'b0;
            frame_done_o  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_trigger_i) begin
                        dec_q       <= aead_dec_i;
                        len_q       <= '0;
                        ok_q        <= 1'b1;    // encrypt/hash frames always report ok
                        auth_fail_o <= 1'b0;
                        state_q     <= S_LO;
                    end
                end
                S_LO: begin
                    if (bdo_xfer) begin
                        lo_q    <= sub_bdo_i;
                        len_q   <= len_inc;
                        state_q <= sub_bdo_last_i ? S_PAD : S_HI;
                    end
                end
                S_HI: begin
                    if (bdo_xfer) begin
                        bdo_fifo_wr_o   <= 1'b1;
                        bdo_fifo_data_o <= {sub_bdo_i, lo_q};
                        len_q           <= len_inc;
                        if (sub_bdo_last_i)
                            state_q <= dec_q ? S_AUTH : S_STAT;
                        else
                            state_q <= S_LO;
                    end
                end
                S_PAD: begin
                    if (!bdo_fifo_full_i) begin
                        bdo_fifo_wr_o   <= 1'b1;
                        bdo_fifo_data_o <= {{DW{1'b0}}, lo_q};
                        state_q         <= dec_q ? S_AUTH : S_STAT;
                    end
                end
                S_AUTH: begin
                    if (sub_auth_vld_i) begin
                        ok_q <= sub_auth_i;
                        if (!sub_auth_i)
                            auth_fail_o <= 1'b1;
                        state_q <= S_STAT;
                    end
                end
                S_STAT: begin
                    if (!bdo_fifo_full_i) begin
                        bdo_fifo_wr_o   <= 1'b1;
                        bdo_fifo_data_o <= status_dat;
                        frame_done_o    <= 1'b1;
                        state_q         <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
